// File: rtl/sakebi_ethernet_tx_arbiter.sv
// Frame-granular round-robin arbiter over N_SRC AXI-Stream sources; 1-cycle arbitration, then zero-latency pass-through.
// Backpressure: i_m_TREADY is routed only to the owner; non-owners see TREADY=0 until the owner's TLAST handshake or timeout.
module sakebi_ethernet_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int N_SRC        = 2,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                        i_axis_ACLK,
  input  logic                        i_axis_ARESETn,
  input  logic [N_SRC-1:0]            i_s_TVALID,
  output logic [N_SRC-1:0]            o_s_TREADY,
  input  logic [N_SRC*DATA_WIDTH-1:0] i_s_TDATA,
  input  logic [N_SRC-1:0]            i_s_TLAST,
  output logic                        o_m_TVALID,
  input  logic                        i_m_TREADY,
  output logic [DATA_WIDTH-1:0]       o_m_TDATA,
  output logic                        o_m_TLAST,
  output logic [N_SRC-1:0]            o_grant,
  output logic                        o_busy,
  output logic                        o_timeout
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_SRC - 1);

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  arb_state_t       state, state_nxt;
  logic [N_SRC-1:0] grant_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] r_last, r_last_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic             timeout_nxt;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;

  // Search starts just after the last owner, so a finishing source drops to lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = {1'b0, r_last} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_SRC)) cand = cand - (IDX_W+1)'(N_SRC);
      if (!pick_vld && i_s_TVALID[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      state     <= ARB_IDLE;
      o_grant   <= '0;
      owner     <= '0;
      r_last    <= LAST_RST;
      idle_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_grant   <= grant_nxt;
      owner     <= owner_nxt;
      r_last    <= r_last_nxt;
      idle_cnt  <= idle_cnt_nxt;
      o_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = o_grant;
    owner_nxt    = owner;
    r_last_nxt   = r_last;
    idle_cnt_nxt = idle_cnt;
    timeout_nxt  = 1'b0;
    o_m_TVALID   = 1'b0;
    o_m_TDATA    = '0;
    o_m_TLAST    = 1'b0;
    o_s_TREADY   = '0;

    case (state)
      ARB_IDLE: begin
        idle_cnt_nxt = '0;
        if (pick_vld) begin
          state_nxt           = ARB_BUSY;
          owner_nxt           = pick_idx;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
        end
      end
      ARB_BUSY: begin
        o_m_TVALID        = i_s_TVALID[owner];
        o_m_TDATA         = i_s_TDATA[owner*DATA_WIDTH +: DATA_WIDTH];
        o_m_TLAST         = i_s_TLAST[owner];
        o_s_TREADY[owner] = i_m_TREADY;
        if (i_s_TVALID[owner]) begin
          idle_cnt_nxt = '0;
          if (i_m_TREADY && i_s_TLAST[owner]) begin
            state_nxt  = ARB_IDLE;
            grant_nxt  = '0;
            r_last_nxt = owner;
          end
        end else if (idle_cnt == CNT_FIRE) begin
          // Stalled owner: release without fabricating TLAST; downstream sees a truncated frame.
          state_nxt    = ARB_IDLE;
          grant_nxt    = '0;
          r_last_nxt   = owner;
          idle_cnt_nxt = '0;
          timeout_nxt  = 1'b1;
        end else if (idle_cnt != CNT_MAX) begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign o_busy = (state == ARB_BUSY);

endmodule

// File: tb/tb_sakebi_ethernet_tx_arbiter.sv
// Bench for sakebi_ethernet_tx_arbiter: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_sakebi_ethernet_tx_arbiter;
  localparam int DW = 8;
  localparam int N  = 3;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_valid, s_ready, s_last;
  logic [N*DW-1:0] s_data;
  logic            m_valid, m_ready, m_last;
  logic [DW-1:0]   m_data;
  logic [N-1:0]    grant;
  logic            busy, timeout;

  int vectors = 0;
  int errors  = 0;

  sakebi_ethernet_tx_arbiter #(.DATA_WIDTH(DW), .N_SRC(N), .IDLE_TIMEOUT(TO)) dut (
    .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
    .i_s_TVALID(s_valid), .o_s_TREADY(s_ready), .i_s_TDATA(s_data), .i_s_TLAST(s_last),
    .o_m_TVALID(m_valid), .i_m_TREADY(m_ready), .o_m_TDATA(m_data), .o_m_TLAST(m_last),
    .o_grant(grant), .o_busy(busy), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 3'b111; s_last = 3'b111; s_data = 24'hFFFFFF; m_ready = 1'b1;
    #1;
    vectors++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b want 000", grant); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    vectors++; if (s_ready !== 3'b000) begin errors++; $display("FAIL reset_s_ready got %b want 000", s_ready); end
    vectors++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
    step();
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    logic [7:0] d [3];
    d[0] = 8'hAA; d[1] = 8'hBB; d[2] = 8'hCC;
    apply_reset();
    s_valid[0] = 1'b1; s_data[7:0] = d[0]; s_last[0] = 1'b0;
    #1;
    vectors++; if (grant !== 3'b000 || m_valid !== 1'b0) begin errors++; $display("FAIL single_decision got grant=%b vld=%b want 000/0", grant, m_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      s_data[7:0] = d[i]; s_last[0] = (i == 2);
      #1;
      vectors++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant beat %0d got %b want 001", i, grant); end
      vectors++; if (m_valid !== 1'b1 || m_data !== d[i]) begin errors++; $display("FAIL single_data beat %0d got %b/%h want 1/%h", i, m_valid, m_data, d[i]); end
      vectors++; if (m_last !== (i == 2)) begin errors++; $display("FAIL single_last beat %0d got %b want %b", i, m_last, (i == 2)); end
      vectors++; if (s_ready !== 3'b001) begin errors++; $display("FAIL single_ready beat %0d got %b want 001", i, s_ready); end
    end
    step();
    s_valid = '0; s_last = '0;
    #1;
    vectors++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL single_release got %b/%b want 000/0", grant, busy); end
  endtask

  task automatic test_alternation();
    logic [2:0] eg;
    apply_reset();
    s_valid = 3'b011; s_last = 3'b011; s_data = 24'h00B1A0;
    #1;
    for (int c = 0; c < 8; c++) begin
      eg = (c % 2 == 0) ? 3'b000 : ((c % 4 == 1) ? 3'b001 : 3'b010);
      vectors++; if (grant !== eg) begin errors++; $display("FAIL alt_grant cycle %0d got %b want %b", c, grant, eg); end
      if (c % 2 == 1) begin
        vectors++; if (m_data !== ((c % 4 == 1) ? 8'hA0 : 8'hB1)) begin errors++; $display("FAIL alt_data cycle %0d got %h", c, m_data); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_no_preempt();
    apply_reset();
    s_valid = 3'b010; s_data[15:8] = 8'h10; s_last = '0;
    #1;
    step();
    vectors++; if (grant !== 3'b010) begin errors++; $display("FAIL nopre_grant got %b want 010", grant); end
    for (int b = 0; b < 3; b++) begin
      if (b == 0) begin s_valid[0] = 1'b1; s_data[7:0] = 8'h55; s_last[0] = 1'b1; end
      s_data[15:8] = 8'h10 + 8'(b); s_last[1] = (b == 2);
      #1;
      vectors++; if (s_ready[0] !== 1'b0) begin errors++; $display("FAIL nopre_ready0 beat %0d got %b want 0", b, s_ready[0]); end
      vectors++; if (m_data !== 8'h10 + 8'(b)) begin errors++; $display("FAIL nopre_data beat %0d got %h want %h", b, m_data, 8'h10 + 8'(b)); end
      step();
    end
    s_valid[1] = 1'b0; s_last[1] = 1'b0;
    #1;
    vectors++; if (grant !== 3'b000 || s_ready[0] !== 1'b0) begin errors++; $display("FAIL nopre_bubble got %b/%b want 000/0", grant, s_ready[0]); end
    step();
    vectors++; if (grant !== 3'b001 || m_data !== 8'h55 || s_ready[0] !== 1'b1) begin errors++; $display("FAIL nopre_src0 got %b/%h/%b want 001/55/1", grant, m_data, s_ready[0]); end
    step();
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [7:0] d [4];
    logic [8:0] got [$];
    int idx = 0;
    bit took;
    for (int i = 0; i < 4; i++) d[i] = 8'h41 + 8'(i);
    apply_reset();
    s_valid[0] = 1'b1; s_data[7:0] = d[0]; s_last[0] = 1'b0;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      m_ready = (cyc % 2 == 0) && !(cyc >= 4 && cyc < 12);
      #1;
      vectors++; if (timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout cycle %0d got 1 want 0", cyc); end
      if (m_valid && m_ready) got.push_back({m_last, m_data});
      took = s_valid[0] && s_ready[0];
      step();
      if (took) begin
        idx++;
        if (idx < 4) begin s_data[7:0] = d[idx]; s_last[0] = (idx == 3); end
        else begin s_valid[0] = 1'b0; s_last[0] = 1'b0; end
      end
    end
    vectors++; if (got.size() != 4) begin errors++; $display("FAIL bp_count got %0d beats want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      vectors++; if (got[i] !== {(i == 3), d[i]}) begin errors++; $display("FAIL bp_beat %0d got %h want %h", i, got[i], {(i == 3), d[i]}); end
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    s_valid = 3'b011; s_data[7:0] = 8'h01; s_data[15:8] = 8'h77; s_last = '0;
    #1;
    step();
    vectors++; if (grant !== 3'b001) begin errors++; $display("FAIL to_grant0 got %b want 001", grant); end
    step();
    s_data[7:0] = 8'h02;
    #1;
    vectors++; if (m_data !== 8'h02) begin errors++; $display("FAIL to_beat2 got %h want 02", m_data); end
    step();
    s_valid[0] = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      #1;
      vectors++; if (timeout !== 1'b0 || grant !== 3'b001) begin errors++; $display("FAIL to_early idle %0d got to=%b grant=%b want 0/001", k, timeout, grant); end
      step();
    end
    vectors++; if (timeout !== 1'b1 || grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL to_pulse got to=%b grant=%b busy=%b want 1/000/0", timeout, grant, busy); end
    step();
    vectors++; if (timeout !== 1'b0 || grant !== 3'b010 || m_data !== 8'h77) begin errors++; $display("FAIL to_next got to=%b grant=%b data=%h want 0/010/77", timeout, grant, m_data); end
    s_last[1] = 1'b1;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    s_valid = 3'b001; s_last = 3'b001; s_data[7:0] = 8'h5A;
    step(); step();
    s_valid = 3'b010; s_last = '0; s_data[15:8] = 8'h61;
    step(); step();
    s_data[15:8] = 8'h62;
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_grant got %b/%b want 000/0", grant, busy); end
    vectors++; if (s_ready !== 3'b000 || m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL rstmid_outs got rdy=%b vld=%b last=%b want 000/0/0", s_ready, m_valid, m_last); end
    step();
    rst_n = 1'b1;
    s_valid = 3'b011; s_data[7:0] = 8'h33;
    #1;
    step();
    vectors++; if (grant !== 3'b001 || m_data !== 8'h33) begin errors++; $display("FAIL rstmid_first got %b/%h want 001/33", grant, m_data); end
    idle_inputs();
    step(); step();
  endtask

  task automatic test_random();
    logic [8:0] srcq [N][$];
    bit took [N];
    int own = -1, last = N - 1, icnt = 0, cyc = 0;
    bit to_exp = 1'b0, to_nxt, pending;
    logic [2:0] eg, er;
    bit ev;
    apply_reset();
    for (int s = 0; s < N; s++) begin
      took[s] = 1'b0;
      for (int f = 0; f < int'($urandom_range(3, 6)); f++) begin
        int len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) srcq[s].push_back({(b == len - 1), 8'($urandom)});
      end
    end
    pending = 1'b1;
    while (pending && cyc < 4000) begin
      for (int s = 0; s < N; s++) begin
        if (!(s_valid[s] && !took[s])) begin
          s_valid[s] = (srcq[s].size() > 0) && ($urandom_range(0, 4) != 0);
          if (srcq[s].size() > 0) begin s_data[s*DW +: DW] = srcq[s][0][7:0]; s_last[s] = srcq[s][0][8]; end
          else s_last[s] = 1'b0;
        end
      end
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      eg = (own < 0) ? 3'b000 : 3'(1 << own);
      er = (own < 0) ? 3'b000 : (3'(m_ready) << own);
      ev = (own >= 0) && s_valid[own];
      vectors++; if (grant !== eg) begin errors++; $display("FAIL rnd_grant cycle %0d got %b want %b", cyc, grant, eg); end
      vectors++; if (busy !== (own >= 0)) begin errors++; $display("FAIL rnd_busy cycle %0d got %b want %b", cyc, busy, (own >= 0)); end
      vectors++; if (timeout !== to_exp) begin errors++; $display("FAIL rnd_timeout cycle %0d got %b want %b", cyc, timeout, to_exp); end
      vectors++; if (m_valid !== ev) begin errors++; $display("FAIL rnd_m_valid cycle %0d got %b want %b", cyc, m_valid, ev); end
      vectors++; if (s_ready !== er) begin errors++; $display("FAIL rnd_s_ready cycle %0d got %b want %b", cyc, s_ready, er); end
      if (ev) begin
        vectors++; if ({m_last, m_data} !== srcq[own][0]) begin errors++; $display("FAIL rnd_beat cycle %0d got %h want %h", cyc, {m_last, m_data}, srcq[own][0]); end
      end
      for (int s = 0; s < N; s++) took[s] = s_valid[s] && er[s];
      to_nxt = 1'b0;
      if (own < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (own < 0 && s_valid[(last + k) % N]) begin own = (last + k) % N; icnt = 0; end
        end
      end else if (ev && m_ready) begin
        icnt = 0;
        if (srcq[own][0][8]) begin last = own; own = -1; end
      end else if (!s_valid[own]) begin
        icnt++;
        if (icnt == TO) begin to_nxt = 1'b1; last = own; own = -1; icnt = 0; end
      end else icnt = 0;
      to_exp = to_nxt;
      for (int s = 0; s < N; s++) if (took[s]) void'(srcq[s].pop_front());
      pending = (own >= 0) || to_exp;
      for (int s = 0; s < N; s++) if (srcq[s].size() > 0) pending = 1'b1;
      step();
      cyc++;
    end
    vectors++; if (pending) begin errors++; $display("FAIL rnd_drain not drained after %0d cycles", cyc); end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_frame();
    test_alternation();
    test_no_preempt();
    test_backpressure();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
